// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: state encodings and counter sizing shared by pulse_stretch
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        GAP  = 2'b10
    } state_t;

    function automatic int cnt_w(input int high_cycles, input int gap_cycles);
        return $clog2((high_cycles > gap_cycles ? high_cycles : gap_cycles) + 1);
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt: up/down counter that saturates at 2^W-1 and floors at 0
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_drop
);

    assign sat_drop = inc && !dec && (&cnt);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (inc && !dec && !(&cnt))
            cnt <= cnt + W'(1);
        else if (dec && !inc && (|cnt))
            cnt <= cnt - W'(1);

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches one-cycle strobes into HIGH_CYCLES-wide pulses with a GAP_CYCLES low gap.
// Define PULSE_STRETCH_OVF_EN to add the sticky ovf flag for requests dropped at a full queue.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HIGH_CYCLES = 5,
    parameter int GAP_CYCLES  = 1,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend
`ifdef PULSE_STRETCH_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int CW = cnt_w(HIGH_CYCLES, GAP_CYCLES);

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic last, again, dec, inc, sat_drop;

    assign last  = cnt == CW'(1);
    // a request arriving in the final cycle counts toward the replay decision
    assign again = (pend != '0) || in;
    assign inc   = in && (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dec      = 1'b0;
        case (state)
            IDLE: if (in) begin
                state_nx = HIGH;
                cnt_nx   = CW'(HIGH_CYCLES);
            end
            HIGH: if (!last) begin
                cnt_nx = cnt - CW'(1);
            end else if (GAP_CYCLES > 0) begin
                state_nx = GAP;
                cnt_nx   = CW'(GAP_CYCLES);
            end else begin
                state_nx = again ? HIGH : IDLE;
                cnt_nx   = again ? CW'(HIGH_CYCLES) : '0;
                dec      = again;
            end
            GAP: if (!last) begin
                cnt_nx = cnt - CW'(1);
            end else begin
                state_nx = again ? HIGH : IDLE;
                cnt_nx   = again ? CW'(HIGH_CYCLES) : '0;
                dec      = again;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            out   <= state_nx == HIGH;
            busy  <= state_nx != IDLE;
        end

    sat_updown_cnt #(.W(PEND_W)) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .cnt      (pend),
        .sat_drop (sat_drop)
    );

`ifdef PULSE_STRETCH_OVF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            ovf <= 1'b0;
        else
            ovf <= ovf | sat_drop;
`else
    wire unused_sat_drop = sat_drop;
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: table-driven check of pulse_stretch (HIGH=5, GAP=1) plus reset corner cases
module tb_pulse_stretch;

    logic clk, rst, in_a, in_b;
    logic out_a, busy_a, out_b, busy_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;
`ifdef PULSE_STRETCH_OVF_EN
    logic ovf_a, ovf_b;
`endif
    int checks = 0;
    int errors = 0;

    pulse_stretch #(.HIGH_CYCLES(5), .GAP_CYCLES(1), .PEND_W(4)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .out(out_a), .busy(busy_a), .pend(pend_a)
`ifdef PULSE_STRETCH_OVF_EN
        , .ovf(ovf_a)
`endif
    );

    pulse_stretch #(.HIGH_CYCLES(5), .GAP_CYCLES(1), .PEND_W(2)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .out(out_b), .busy(busy_b), .pend(pend_b)
`ifdef PULSE_STRETCH_OVF_EN
        , .ovf(ovf_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string name;
        bit    sat;
        string in_s;
        string out_s;
        string busy_s;
        string pend_s;
        string ovf_s;
    } vec_t;

    vec_t tbl[7];

    function automatic int d(input string s, input int c);
        return int'(s.getc(c)) - 48;
    endfunction

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, got, exp);
        end
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic run(input vec_t v);
        do_reset;
        for (int c = 0; c < v.in_s.len(); c++) begin
            @(posedge clk);
            #1;
            if (v.sat) begin
                chk({v.name, ".out"}, c, int'(out_b), d(v.out_s, c));
                chk({v.name, ".busy"}, c, int'(busy_b), d(v.busy_s, c));
                chk({v.name, ".pend"}, c, int'(pend_b), d(v.pend_s, c));
`ifdef PULSE_STRETCH_OVF_EN
                chk({v.name, ".ovf"}, c, int'(ovf_b), d(v.ovf_s, c));
`endif
                in_b = d(v.in_s, c) == 1;
            end else begin
                chk({v.name, ".out"}, c, int'(out_a), d(v.out_s, c));
                chk({v.name, ".busy"}, c, int'(busy_a), d(v.busy_s, c));
                chk({v.name, ".pend"}, c, int'(pend_a), d(v.pend_s, c));
                in_a = d(v.in_s, c) == 1;
            end
        end
        in_a = 1'b0;
        in_b = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"single", 1'b0, "10000000000000000000", "01111100000000000000",
                   "01111110000000000000", "00000000000000000000", ""};
        tbl[1] = '{"queued", 1'b0, "10100000000000000000", "01111101111100000000",
                   "01111111111110000000", "00011110000000000000", ""};
        tbl[2] = '{"held", 1'b0, "11100000000000000000", "01111101111101111100",
                   "01111111111111111110", "00122221111110000000", ""};
        tbl[3] = '{"incdec", 1'b0, "10100010000000000000", "01111101111101111100",
                   "01111111111111111110", "00011111111110000000", ""};
        tbl[4] = '{"last_high", 1'b0, "10000100000000000000", "01111101111100000000",
                   "01111111111110000000", "00000010000000000000", ""};
        tbl[5] = '{"last_gap", 1'b0, "10000010000000000000", "01111101111100000000",
                   "01111111111110000000", "00000000000000000000", ""};
        tbl[6] = '{"sat", 1'b1, "1111110000000000000000000000", "0111110111110111110111110000",
                   "0111111111111111111111111000", "0012333222222111111000000000",
                   "0000011111111111111111111111"};

        rst  = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        #2;
        chk("rst.out", 0, int'(out_a), 0);
        chk("rst.busy", 0, int'(busy_a), 0);
        chk("rst.pend", 0, int'(pend_a), 0);
        chk("rst.pend_b", 0, int'(pend_b), 0);
`ifdef PULSE_STRETCH_OVF_EN
        chk("rst.ovf", 0, int'(ovf_b), 0);
`endif

        foreach (tbl[i]) run(tbl[i]);

        // asynchronous reset in the middle of the first pulse with a request queued
        do_reset;
        @(posedge clk); #1; in_a = 1'b1;
        @(posedge clk); #1; in_a = 1'b0;
        chk("arst.out_c1", 1, int'(out_a), 1);
        @(posedge clk); #1; in_a = 1'b1;
        @(posedge clk); #1; in_a = 1'b0;
        chk("arst.pend_c3", 3, int'(pend_a), 1);
        chk("arst.out_c3", 3, int'(out_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_now", 3, int'(out_a), 0);
        chk("arst.busy_now", 3, int'(busy_a), 0);
        chk("arst.pend_now", 3, int'(pend_a), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("restart.out_c0", 0, int'(out_a), 0);
        chk("restart.busy_c0", 0, int'(busy_a), 0);
        in_a = 1'b1;
        @(posedge clk); #1;
        in_a = 1'b0;
        chk("restart.out_c1", 1, int'(out_a), 1);
        chk("restart.busy_c1", 1, int'(busy_a), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("restart.out_c7", 7, int'(out_a), 0);
        chk("restart.busy_c7", 7, int'(busy_a), 0);
        chk("restart.pend_c7", 7, int'(pend_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
